// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the counter bank.
//   - sys_state_e    : transaction-layer system state encodings (one-hot)
//   - state_cnt_en() : counters may advance in this state
//   - state_clr()    : counters and overflow flags are forced to zero in this state
// Any state value outside the four encodings is treated as an error state.
// In that state counters hold and increments are ignored.
package counter_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } sys_state_e;

    function automatic logic state_cnt_en(input logic [3:0] st);
        return (st == 4'(ST_IDLE)) || (st == 4'(ST_ACTIVE));
    endfunction

    function automatic logic state_clr(input logic [3:0] st);
        return (st == 4'(ST_RESET)) || (st == 4'(ST_INIT));
    endfunction

endpackage

// File: rtl/counter_chan.sv
// counter_chan: one channel of the counter bank.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count strobe, one count per cycle high
//   en         : count enable, derived from the system state
//   clr        : synchronous clear of the counter and the flag; wins over inc
//   rd_clr     : clear-on-read of this channel; a coincident inc still counts
//   cnt        : current count
//   ovf        : sticky overflow flag
module counter_chan
    import counter_pkg::*;
#(
    parameter int CNT_W    = 5,
    parameter bit SAT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             en,
    input  logic             clr,
    input  logic             rd_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             ovf_q, ovf_d, ovf_base;

    always_comb begin
        // A read clear is applied first, so an increment on the same edge
        // lands on zero and leaves the counter at one.
        cnt_base = rd_clr ? '0 : cnt_q;
        ovf_base = rd_clr ? 1'b0 : ovf_q;
        cnt_d    = cnt_base;
        ovf_d    = ovf_base;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en && inc) begin
            if (cnt_base == CNT_MAX) begin
                ovf_d = 1'b1;
                cnt_d = SAT_MODE ? CNT_MAX : '0;
            end else begin
                cnt_d = cnt_base + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/counter_bank.sv
// counter_bank: bank of per-channel event counters with a muxed readout port.
//   clk, reset : clock, asynchronous active-high reset
//   state      : system state (encodings in counter_pkg)
//   inc        : per-channel increment strobes
//   req, idx   : read request and channel index
//   data       : read data, registered; zero when valid is low
//   valid      : one-cycle pulse per accepted read
//   rd_err     : one-cycle pulse per request with an out-of-range index
//   overflow   : sticky per-channel overflow flags
// Reads return the count as it was before the sampling edge.
module counter_bank
    import counter_pkg::*;
#(
    parameter int NUM_CH      = 5,
    parameter int CNT_W       = 5,
    parameter bit SAT_MODE    = 1'b0,
    parameter bit CLR_ON_READ = 1'b0,
    parameter int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        state,
    input  logic [NUM_CH-1:0] inc,
    input  logic              req,
    input  logic [IDX_W-1:0]  idx,
    output logic [CNT_W-1:0]  data,
    output logic              valid,
    output logic              rd_err,
    output logic [NUM_CH-1:0] overflow
);

    logic [CNT_W-1:0]  cnt_arr [NUM_CH];
    logic [NUM_CH-1:0] rd_clr;
    logic [CNT_W-1:0]  rd_sel;
    logic              idx_ok;
    logic              cnt_en, st_clr;

    logic [CNT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             rd_err_q, rd_err_d;

    assign cnt_en = state_cnt_en(state);
    assign st_clr = state_clr(state);
    // Extra bit keeps the compare meaningful when NUM_CH is a power of two.
    assign idx_ok = ({1'b0, idx} < (IDX_W+1)'(NUM_CH));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        counter_chan #(
            .CNT_W    (CNT_W),
            .SAT_MODE (SAT_MODE)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .inc    (inc[g]),
            .en     (cnt_en),
            .clr    (st_clr),
            .rd_clr (rd_clr[g]),
            .cnt    (cnt_arr[g]),
            .ovf    (overflow[g])
        );
    end

    always_comb begin
        rd_sel = '0;
        rd_clr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req && (idx == IDX_W'(i))) begin
                rd_sel    = cnt_arr[i];
                rd_clr[i] = CLR_ON_READ;
            end
        end
        valid_d  = req && idx_ok;
        rd_err_d = req && !idx_ok;
        data_d   = valid_d ? rd_sel : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign data   = data_q;
    assign valid  = valid_q;
    assign rd_err = rd_err_q;

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: two banks driven by the same stimulus.
//   dut_a : wrap mode, no clear-on-read
//   dut_b : saturate mode, clear-on-read
// A behavioural model of both banks predicts data/valid/rd_err/overflow every cycle.
module tb_counter_bank;
    import counter_pkg::*;

    localparam int NCH  = 5;
    localparam int CMAX = 31;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     state;
    logic [NCH-1:0] inc;
    logic           req;
    logic [2:0]     idx;

    logic [4:0]     data_a, data_b;
    logic           valid_a, valid_b, rd_err_a, rd_err_b;
    logic [NCH-1:0] ovf_a, ovf_b;

    int n_chk  = 0;
    int n_pass = 0;

    int m_cnt [2][NCH];
    bit m_ovf [2][NCH];
    int e_data [2];
    bit e_valid [2];
    bit e_err [2];

    always #5 clk = ~clk;

    counter_bank #(.NUM_CH(NCH), .CNT_W(5), .SAT_MODE(1'b0), .CLR_ON_READ(1'b0)) dut_a (
        .clk(clk), .reset(reset), .state(state), .inc(inc), .req(req), .idx(idx),
        .data(data_a), .valid(valid_a), .rd_err(rd_err_a), .overflow(ovf_a));

    counter_bank #(.NUM_CH(NCH), .CNT_W(5), .SAT_MODE(1'b1), .CLR_ON_READ(1'b1)) dut_b (
        .clk(clk), .reset(reset), .state(state), .inc(inc), .req(req), .idx(idx),
        .data(data_b), .valid(valid_b), .rd_err(rd_err_b), .overflow(ovf_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_data[k] = 0; e_valid[k] = 0; e_err[k] = 0;
            for (int i = 0; i < NCH; i++) begin
                m_cnt[k][i] = 0;
                m_ovf[k][i] = 0;
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_ovf(input int k);
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_ovf[k][i];
        return v;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_data_a"},  32'(data_a),   32'(e_data[0]));
        check({tag, "_valid_a"}, 32'(valid_a),  32'(e_valid[0]));
        check({tag, "_err_a"},   32'(rd_err_a), 32'(e_err[0]));
        check({tag, "_ovf_a"},   32'(ovf_a),    32'(exp_ovf(0)));
        check({tag, "_data_b"},  32'(data_b),   32'(e_data[1]));
        check({tag, "_valid_b"}, 32'(valid_b),  32'(e_valid[1]));
        check({tag, "_err_b"},   32'(rd_err_b), 32'(e_err[1]));
        check({tag, "_ovf_b"},   32'(ovf_b),    32'(exp_ovf(1)));
    endtask

    // Predict the effect of the coming edge from the current inputs, then
    // let the edge happen and compare just after it.
    task automatic step(input string tag);
        bit counting, clearing, accepted;
        if (reset) begin
            model_reset();
        end else begin
            counting = (state == ST_IDLE) || (state == ST_ACTIVE);
            clearing = (state == ST_RESET) || (state == ST_INIT);
            accepted = req && (int'(idx) < NCH);
            for (int k = 0; k < 2; k++) begin
                e_valid[k] = accepted;
                e_err[k]   = req && !accepted;
                e_data[k]  = accepted ? m_cnt[k][idx] : 0;
                for (int i = 0; i < NCH; i++) begin
                    if (clearing) begin
                        m_cnt[k][i] = 0;
                        m_ovf[k][i] = 0;
                    end else begin
                        if (k == 1 && accepted && int'(idx) == i) begin
                            m_cnt[k][i] = 0;
                            m_ovf[k][i] = 0;
                        end
                        if (counting && inc[i]) begin
                            m_cnt[k][i] = m_cnt[k][i] + 1;
                            if (m_cnt[k][i] > CMAX) begin
                                m_ovf[k][i] = 1;
                                m_cnt[k][i] = (k == 1) ? CMAX : 0;
                            end
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [3:0] st_rand;
        int r;

        reset = 1'b1; state = ST_IDLE; inc = '0; req = 1'b0; idx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("rst");
        reset = 1'b0;

        // reset/idle: every channel reads zero
        for (int ch = 0; ch < NCH; ch++) begin
            req = 1'b1; idx = 3'(ch);
            step("idle_rd");
            check("idle_valid", 32'(valid_a), 32'd1);
            check("idle_zero",  32'(data_b),  32'd0);
        end
        req = 1'b0;

        // counting: ch2 seven times, ch0 three times
        state = ST_ACTIVE;
        for (int c = 0; c < 7; c++) begin
            inc = '0; inc[2] = 1'b1; inc[0] = (c < 3);
            step("cnt");
        end
        inc = '0; req = 1'b1; idx = 3'd2;
        step("cnt_rd2");
        check("cnt_ch2", 32'(data_a), 32'd7);
        idx = 3'd0;
        step("cnt_rd0");
        check("cnt_ch0", 32'(data_a), 32'd3);
        req = 1'b0;

        // wrap vs saturate: 33 increments on ch1
        inc = 5'b00010;
        for (int c = 0; c < 33; c++) step("wrap");
        inc = '0;
        check("wrap_ovf_a", 32'(ovf_a[1]), 32'd1);
        check("sat_ovf_b",  32'(ovf_b[1]), 32'd1);
        req = 1'b1; idx = 3'd1;
        step("wrap_rd");
        check("wrap_data", 32'(data_a), 32'd1);
        check("sat_data",  32'(data_b), 32'd31);
        req = 1'b0;

        // clear-on-read with coincident increment on ch3
        state = ST_INIT; step("cor_init");
        state = ST_ACTIVE; inc = 5'b01000;
        for (int c = 0; c < 4; c++) step("cor_cnt");
        req = 1'b1; idx = 3'd3;
        step("cor_rd1");
        check("cor_first", 32'(data_b), 32'd4);
        inc = '0;
        step("cor_rd2");
        check("cor_second_b", 32'(data_b), 32'd1);
        check("cor_second_a", 32'(data_a), 32'd5);
        check("cor_ovf3",     32'(ovf_b[3]), 32'd0);
        req = 1'b0;

        // gating: ch4 to 6, INIT clears, error state ignores inc
        inc = 5'b10000;
        for (int c = 0; c < 6; c++) step("gate_cnt");
        state = ST_INIT; step("gate_init");
        state = 4'b0000;
        step("gate_err"); step("gate_err");
        inc = '0; req = 1'b1; idx = 3'd4;
        step("gate_rd");
        check("gate_data", 32'(data_a), 32'd0);
        idx = 3'd5;
        step("bad_idx");
        check("bad_rd_err", 32'(rd_err_a), 32'd1);
        check("bad_valid",  32'(valid_b),  32'd0);
        req = 1'b0;

        // async reset between a request and its sampling edge
        state = ST_ACTIVE; inc = 5'b00001;
        step("mr_cnt"); step("mr_cnt");
        inc = '0; req = 1'b1; idx = 3'd0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("mr_async");
        @(posedge clk);
        #1;
        compare_all("mr_held");
        #2;
        reset = 1'b0; req = 1'b0;
        step("mr_rel");
        check("mr_no_pulse", 32'(valid_a), 32'd0);
        req = 1'b1; idx = 3'd0;
        step("mr_rd");
        check("mr_cleared", 32'(data_a), 32'd0);
        req = 1'b0;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 49);
            if (r < 25)       state = ST_ACTIVE;
            else if (r < 45)  state = ST_IDLE;
            else if (r == 45) state = ST_INIT;
            else if (r == 46) state = ST_RESET;
            else begin
                st_rand = 4'($urandom_range(0, 15));
                if ($countones(st_rand) == 1) st_rand = 4'b1111;
                state = st_rand;
            end
            inc = NCH'($urandom);
            req = ($urandom_range(0, 2) == 0);
            idx = 3'($urandom_range(0, 7));
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
